// File: rtl/chip8_fetch_unit.sv
// chip8_fetch_unit
//   Instruction-fetch stage for the CHIP-8 CPU. It holds the program counter and a
//   call stack. Each instruction is read as two bytes from byte-wide program RAM
//   and is presented to decode as a big-endian 16-bit word over valid/ready. On
//   each accepted instruction it applies the PC update that decode selects.
//
// Ports
//   cpu_clk      in   clock, rising edge
//   reset_n      in   synchronous active-low reset
//   mem_addr     out  program RAM byte address (0 when no read is issued)
//   mem_re       out  read strobe; mem_rdata returns one cycle later
//   mem_rdata    in   RAM read data
//   instr        out  fetched instruction {byte@pc, byte@pc+1}
//   instr_valid  out  instr and pc are valid
//   instr_ready  in   decode accepts instr this cycle
//   pc           out  address of the presented instruction
//   pc_cmd       in   0 NEXT, 1 SKIP, 2 JUMP, 3 CALL, 4 RET, others NEXT
//   pc_target    in   target for JUMP and CALL
//   stack_depth  out  occupied stack entries
//   fault        out  sticky stack overflow/underflow flag
module chip8_fetch_unit #(
  parameter logic [11:0] RESET_PC    = 12'h200,
  parameter int unsigned STACK_DEPTH = 16,
  localparam int unsigned DepthW     = $clog2(STACK_DEPTH) + 1
) (
  input  logic              cpu_clk,
  input  logic              reset_n,
  output logic [11:0]       mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [11:0]       pc,
  input  logic [2:0]        pc_cmd,
  input  logic [11:0]       pc_target,
  output logic [DepthW-1:0] stack_depth,
  output logic              fault
);

  // Stack pointer width; STACK_DEPTH is expected to be at least 2.
  localparam int unsigned PtrW = DepthW - 1;

  localparam logic [2:0] CmdNext = 3'd0;
  localparam logic [2:0] CmdSkip = 3'd1;
  localparam logic [2:0] CmdJump = 3'd2;
  localparam logic [2:0] CmdCall = 3'd3;
  localparam logic [2:0] CmdRet  = 3'd4;

  typedef enum logic [2:0] {
    StFetchHi,
    StFetchLo,
    StWaitLo,
    StPresent,
    StFault
  } state_e;

  state_e              state_q, state_d;
  logic [11:0]         pc_q, pc_d;
  logic [15:0]         instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [DepthW-1:0]   depth_q, depth_d;
  logic                fault_q, fault_d;

  logic [11:0]         stack_q [STACK_DEPTH];
  logic                push_en;

  logic [11:0]         pc_plus1, pc_plus2, pc_plus4;
  logic [DepthW-1:0]   depth_dec;
  logic                stack_full, stack_empty;
  logic                xfer;

  assign pc_plus1    = pc_q + 12'd1;
  assign pc_plus2    = pc_q + 12'd2;
  assign pc_plus4    = pc_q + 12'd4;
  assign depth_dec   = depth_q - DepthW'(1);
  assign stack_full  = (depth_q == DepthW'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  assign xfer        = valid_q & instr_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    depth_d  = depth_q;
    fault_d  = fault_q;
    push_en  = 1'b0;
    mem_re   = 1'b0;
    mem_addr = 12'h000;

    unique case (state_q)
      StFetchHi: begin
        mem_re   = 1'b1;
        mem_addr = pc_q;
        state_d  = StFetchLo;
      end
      StFetchLo: begin
        mem_re        = 1'b1;
        mem_addr      = pc_plus1;
        instr_d[15:8] = mem_rdata;
        state_d       = StWaitLo;
      end
      StWaitLo: begin
        instr_d[7:0] = mem_rdata;
        valid_d      = 1'b1;
        state_d      = StPresent;
      end
      StPresent: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = StFetchHi;
          case (pc_cmd)
            CmdSkip: pc_d = pc_plus4;
            CmdJump: pc_d = pc_target;
            CmdCall: begin
              if (stack_full) begin
                fault_d = 1'b1;
                state_d = StFault;
              end else begin
                push_en = 1'b1;
                depth_d = depth_q + DepthW'(1);
                pc_d    = pc_target;
              end
            end
            CmdRet: begin
              if (stack_empty) begin
                fault_d = 1'b1;
                state_d = StFault;
              end else begin
                pc_d    = stack_q[depth_dec[PtrW-1:0]];
                depth_d = depth_dec;
              end
            end
            default: pc_d = pc_plus2;
          endcase
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StFetchHi;
      end
    endcase

    // Reset values show on the read port for as long as reset is held, so a
    // restart never issues a read while reset_n is low.
    if (!reset_n) begin
      mem_re   = 1'b0;
      mem_addr = 12'h000;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!reset_n) begin
      state_q <= StFetchHi;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  // Stack contents survive reset; only the depth is cleared.
  always_ff @(posedge cpu_clk) begin
    if (reset_n && push_en) begin
      stack_q[depth_q[PtrW-1:0]] <= pc_plus2;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign stack_depth = depth_q;
  assign fault       = fault_q;

endmodule
